// File: rtl/seven_seg_scan.sv
// seven_seg_scan
// Drives a common-anode 7-segment display by time-multiplexing a packed
// DIGITS-wide hex value. Each anode gets one DIV-cycle slot. The first BLANK
// cycles of every slot have all anodes off so that the previous digit's
// segments cannot ghost onto the next anode. New values wait in a pending
// register and are only taken over at the frame boundary, so a frame never
// mixes digits from two values. Leading zeros can optionally be suppressed.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   in          packed hex digits, digit k = in[4k+3:4k]
//   load        single-cycle strobe that captures in and dp_in
//   dp_in       decimal-point enables, bit k for digit k
//   lz_blank    live leading-zero suppression enable
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   dp          decimal point, active-low, registered
//   an          anode enables, active-low, registered
//   frame_done  one-cycle pulse in the last cycle of a full scan
//   busy        a captured value is waiting for the frame boundary
//
// Slot phase FSM
//   state    | meaning
//   PH_BLANK | slot counter in 0..BLANK-1, all anodes off
//   PH_SHOW  | slot counter in BLANK..DIV-1, anode idx on
module seven_seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*4-1:0]   in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  phase_t phase, phase_nx;

  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic                  slot_end;
  logic                  frame_end;

  logic [DIGITS*4-1:0]   pend;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_vld;
  logic [DIGITS*4-1:0]   disp, disp_nx;
  logic [DIGITS-1:0]     disp_dp, disp_dp_nx;

  logic [6:0]            seg_nx;
  logic                  dp_nx;
  logic [DIGITS-1:0]     an_nx;
  logic                  frame_done_nx;

  logic [3:0]            digit_nx;
  logic                  upper_zero;
  logic                  suppress;

  // Active-low {g,f,e,d,c,b,a} patterns for one hex digit.
  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot counter and digit index. frame_end is the last cycle of the last
  // slot, i.e. the cycle in which idx is about to wrap back to 0.
  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    cnt_nx    = slot_end ? '0 : cnt + CW'(1);
    idx_nx    = idx;
    if (slot_end) begin
      idx_nx = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nx;
      idx <= idx_nx;
    end
  end

  // Display register update. A load in the boundary cycle beats anything
  // already pending because it is the most recent value.
  always_comb begin
    disp_nx    = disp;
    disp_dp_nx = disp_dp;
    if (frame_end) begin
      if (load) begin
        disp_nx    = in;
        disp_dp_nx = dp_in;
      end else if (pend_vld) begin
        disp_nx    = pend;
        disp_dp_nx = pend_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      disp     <= '0;
      disp_dp  <= '0;
    end else begin
      disp    <= disp_nx;
      disp_dp <= disp_dp_nx;
      if (frame_end) begin
        pend_vld <= 1'b0;
      end else if (load) begin
        pend     <= in;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end
    end
  end

  assign busy = pend_vld;

  // Phase FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= PH_BLANK;
    end else begin
      phase <= phase_nx;
    end
  end

  // Phase FSM: next state. Evaluated against the counter value being entered
  // so that the registered outputs line up with the counter they describe.
  always_comb begin
    phase_nx = phase;
    case (phase)
      PH_BLANK: if (cnt_nx == BLANK_END) phase_nx = PH_SHOW;
      PH_SHOW:  if (slot_end)            phase_nx = PH_BLANK;
      default:                           phase_nx = PH_BLANK;
    endcase
  end

  // Leading-zero test for the digit about to be shown: blank it when it and
  // every digit above it are zero. Digit 0 is always shown.
  always_comb begin
    digit_nx   = disp_nx[idx_nx*4 +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((IW'(j) >= idx_nx) && (disp_nx[j*4 +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    suppress = lz_blank && (idx_nx != '0) && upper_zero;
  end

  // Phase FSM: outputs. The anode stays driven for a suppressed digit so slot
  // timing is identical either way.
  always_comb begin
    an_nx         = '1;
    seg_nx        = '1;
    dp_nx         = 1'b1;
    frame_done_nx = (cnt_nx == CNT_LAST) && (idx_nx == IDX_LAST);
    if (phase_nx == PH_SHOW) begin
      an_nx[idx_nx] = 1'b0;
      if (!suppress) begin
        seg_nx = decode(digit_nx);
        dp_nx  = ~disp_dp_nx[idx_nx];
      end
    end
  end

  // All display-facing outputs come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nx;
      seg        <= seg_nx;
      dp         <= dp_nx;
      frame_done <= frame_done_nx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        busy;

  seven_seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .load       (load),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       busy;
    int         t;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;

  // Reference model state: cycle index since reset release, the value shown
  // in the current frame, the most recent load, and whether a load has been
  // made earlier in the current frame.
  int          t;
  logic [15:0] shown, latest;
  logic [3:0]  shown_dp, latest_dp;
  bit          busy_f, lz_f;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    logic [6:0] tbl [16];
    tbl[0]  = 7'b1000000; tbl[1]  = 7'b1111001; tbl[2]  = 7'b0100100; tbl[3]  = 7'b0110000;
    tbl[4]  = 7'b0011001; tbl[5]  = 7'b0010010; tbl[6]  = 7'b0000010; tbl[7]  = 7'b1111000;
    tbl[8]  = 7'b0000000; tbl[9]  = 7'b0010000; tbl[10] = 7'b0001000; tbl[11] = 7'b0000011;
    tbl[12] = 7'b1000110; tbl[13] = 7'b0100001; tbl[14] = 7'b0000110; tbl[15] = 7'b0001110;
    return tbl[h];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input int tc);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, tc, act, req);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; compare it on
  // the falling edge against the expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_pop++;
      chk("an",         32'(an),         32'(e.an),   e.t);
      chk("seg",        32'(seg),        32'(e.seg),  e.t);
      chk("dp",         32'(dp),         32'(e.dp),   e.t);
      chk("frame_done", 32'(frame_done), 32'(e.fd),   e.t);
      chk("busy",       32'(busy),       32'(e.busy), e.t);
    end
  end

  task automatic model_reset();
    t         = 0;
    shown     = '0;
    latest    = '0;
    shown_dp  = '0;
    latest_dp = '0;
    busy_f    = 0;
    lz_f      = 0;
  endtask

  // One cycle: queue the expected outputs for the current cycle from the
  // frame-level rules, then apply this cycle's stimulus.
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit lzv);
    int fpos, pos, slot;
    exp_t e;
    bit blk;
    fpos = t % FRAME;
    pos  = t % DIV;
    slot = (t / DIV) % DIGITS;
    if (fpos == 0) begin
      shown    = latest;
      shown_dp = latest_dp;
      busy_f   = 0;
      lz_f     = lzv;
      lz_blank = lzv;
    end
    e.t    = t;
    e.busy = busy_f;
    e.fd   = (fpos == FRAME - 1);
    if (pos < BLANK) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end else begin
      e.an       = 4'hF;
      e.an[slot] = 1'b0;
      blk   = lz_f && (slot != 0) && ((shown >> (slot * 4)) == 16'h0);
      e.seg = blk ? 7'h7F : ref_seg(shown[slot*4 +: 4]);
      e.dp  = blk ? 1'b1 : ~shown_dp[slot];
    end
    exp_q.push_back(e);
    n_push++;
    load  = ld;
    in    = v;
    dp_in = d;
    if (ld) begin
      latest    = v;
      latest_dp = d;
      busy_f    = 1;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    t++;
  endtask

  task automatic frame(input bit lzv,
                       input int c1, input logic [15:0] v1, input logic [3:0] d1,
                       input int c2, input logic [15:0] v2, input logic [3:0] d2);
    for (int c = 0; c < FRAME; c++) begin
      if (c == c1)      step(1'b1, v1, d1, lzv);
      else if (c == c2) step(1'b1, v2, d2, lzv);
      else              step(1'b0, 16'($urandom), 4'($urandom), lzv);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in       = '0;
    load     = 1'b0;
    dp_in    = '0;
    lz_blank = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_an",   32'(an),         32'hF,  -1);
    chk("reset_seg",  32'(seg),        32'h7F, -1);
    chk("reset_dp",   32'(dp),         32'h1,  -1);
    chk("reset_fd",   32'(frame_done), 32'h0,  -1);
    chk("reset_busy", 32'(busy),       32'h0,  -1);
    reset = 1'b1;

    // Idle frame, then the 12AF load with dp on digit 2.
    frame(1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame(1'b0, 10, 16'h12AF, 4'b0100, -1, 16'h0, 4'h0);
    frame(1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // Two loads in one frame: last one wins.
    frame(1'b0, 5, 16'h1111, 4'h0, 20, 16'h2222, 4'h0);
    frame(1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // Load in the boundary cycle itself.
    frame(1'b0, FRAME - 1, 16'h5A5A, 4'b1001, -1, 16'h0, 4'h0);
    frame(1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // Leading-zero suppression, including a dp bit on a blanked digit.
    frame(1'b1, 8, 16'h0040, 4'b0110, -1, 16'h0, 4'h0);
    frame(1'b1, 8, 16'h0000, 4'b1111, -1, 16'h0, 4'h0);
    frame(1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Randomized frames, biased toward values with leading zeros.
    for (int f = 0; f < 12; f++) begin
      bit lzr;
      lzr = 1'($urandom_range(0, 1));
      for (int c = 0; c < FRAME; c++) begin
        bit ld;
        logic [15:0] v;
        ld = ($urandom_range(0, 5) == 0);
        v  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
        step(ld, v, 4'($urandom), lzr);
      end
    end

    // Mid-slot reset with a pending load; the pending value must be lost.
    for (int c = 0; c < 13; c++) step(c == 5, 16'h9876, 4'hF, 1'b0);
    chk("pre_reset_busy", 32'(busy), 32'h1, t);
    chk("pre_reset_an",   32'(an),   32'hD, t);
    #1;
    reset = 1'b0;
    #1;
    chk("async_an",   32'(an),   32'hF,  t);
    chk("async_seg",  32'(seg),  32'h7F, t);
    chk("async_dp",   32'(dp),   32'h1,  t);
    chk("async_busy", 32'(busy), 32'h0,  t);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    frame(1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame(1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0, t);
    chk("scoreboard_pops",    32'(n_pop),        32'(n_push), t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Display-side counterpart of the keypad input path.
- Takes a packed DIGITS-wide hex value, such as a keypad or adder result register, and time-multiplexes it onto a common-anode 7-segment display.
- The keypad block scans columns and reads rows; this block scans anodes and drives segments.
- Adds tear-free frame-synchronous loading, anti-ghosting blanking and optional leading-zero suppression.

Parameters:
DIGITS, 4, number of hex digits and anodes (1..8)
DIV, 50000, clock cycles per digit slot (>= BLANK+2)
BLANK, 500, cycles at the start of each slot with all anodes off (>= 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
in  input  DIGITS*4  packed hex digits; digit k = in[4k+3:4k], digit 0 least significant
load  input  1  single-cycle strobe; capture in for display
dp_in  input  DIGITS  decimal-point enables, bit k for digit k, captured with in
lz_blank  input  1  1 = suppress leading zeros (live input, not captured)
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
an  output  DIGITS  anode enables, active-low, one-hot-low or all ones
frame_done  output  1  one-cycle pulse at the end of each full scan
busy  output  1  1 while a captured value waits for the frame boundary

Behaviour:
- Reset (reset=0, async):
  - an, seg and dp all ones; frame_done=0; busy=0.
  - Slot counter=0, digit index=0.
  - Display register and dp register cleared to 0.
  - Pending register invalid.
- Outputs: seg, dp and an come straight from flops, so they are glitch-free.
- Slot timing:
  - Counter runs 0..DIV-1, then wraps.
  - Counter values 0..BLANK-1: an all ones, seg all ones, dp=1.
  - Counter values BLANK..DIV-1: an[idx]=0, seg/dp show digit idx.
  - After reset release, observed outputs are: BLANK cycles blank, then DIV-BLANK cycles of digit 0, then digit 1, and so on.
  - idx increments when the counter wraps; idx wraps from DIGITS-1 to 0.
- frame_done: 1 for exactly one cycle, the cycle in which idx wraps from DIGITS-1 to 0.
- Loading (tear-free):
  - load=1 stores in and dp_in into pending and sets busy=1.
  - At the frame boundary (the frame_done cycle), pending is copied to the display register and busy clears.
  - A load in the boundary cycle itself goes directly to the display register, takes priority over older pending data, and leaves busy=0.
  - Multiple loads within one frame: last one wins.
  - Reset mid-frame discards pending data.
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero suppression (lz_blank=1):
  - Digit k is blanked (seg all ones, dp=1) if digit k and every digit above it are zero.
  - Digit 0 is never blanked.
  - The anode is still driven for a blanked digit, so slot timing is unchanged.
  - A set dp bit on a blanked digit is suppressed.
- dp: active-low copy of the captured dp bit for digit idx, subject to the blanking rules above.

Test Plan:
- DIGITS=4, DIV=8, BLANK=2; release reset with no load → repeating 32-cycle frame. Each 8-cycle slot is 2 cycles an=1111, then 6 cycles an=1110/1101/1011/0111 in turn with seg=1000000. frame_done pulses every 32 cycles.
- load with in=16'h12AF, dp_in=4'b0100 mid-frame → busy=1 until frame_done. The next frame shows digit0=0001110 (F), digit1=0001000 (A), digit2=0100100 (2) with dp=0, digit3=1111001 (1). No digit of the old value appears after the boundary.
- Two loads in one frame, 16'h1111 then 16'h2222 → only 2222 is displayed next frame.
- load in the exact frame_done cycle → value is displayed from the following slot 0; busy stays 0.
- lz_blank=1, in=16'h0040 → digits 3 and 2 blank (seg=1111111) with their an still pulsed; digit1=0011001 (4), digit0=1000000 (0). With in=16'h0000, only digit 0 shows 0.
- Assert reset mid-slot with a pending load → an, seg and dp go to all ones immediately (async). After release, display=0, busy=0, idx=0, and the counter restarts from 0.
